conv_tile_scheduler: RTL and testbench



---
 rtl/conv_tile_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the single-row-tile convolution MAC datapath: fetches weights
// and pixel windows, launches kernel loops, hands results downstream, clears the MACs.
module conv_tile_scheduler #(
  parameter int kx       = 3,
  parameter int Pix      = 3,
  parameter int RES      = 8,
  parameter int MAX_ROWS = 64,
  parameter int MAX_OC   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_num_rows,
  input  logic [$clog2(MAX_OC+1)-1:0]   cfg_num_oc,
  output logic                          wt_req,
  output logic [$clog2(MAX_OC)-1:0]     wt_oc,
  input  logic                          wt_ack,
  output logic                          row_req,
  output logic [$clog2(MAX_ROWS)-1:0]   row_idx,
  input  logic                          row_ack,
  output logic                          pixel_ready,
  output logic                          weight_ready,
  output logic                          MAC_clear,
  input  logic                          kernel_loop_done,
  input  logic [Pix*RES-1:0]            acc_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Pix*RES-1:0]            out_data,
  output logic [$clog2(MAX_ROWS)-1:0]   out_row,
  output logic [$clog2(MAX_OC)-1:0]     out_oc,
  output logic                          busy,
  output logic                          done
);

  localparam int RW  = $clog2(MAX_ROWS);
  localparam int OW  = $clog2(MAX_OC);
  localparam int NRW = $clog2(MAX_ROWS+1);
  localparam int NOW = $clog2(MAX_OC+1);

  if (kx < 1 || Pix < 1 || RES < 1) begin : g_bad_cfg
    $error("conv_tile_scheduler: kx, Pix and RES must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_W   = 3'd1,
    S_FETCH_ROW = 3'd2,
    S_LAUNCH    = 3'd3,
    S_RUN       = 3'd4,
    S_DRAIN     = 3'd5,
    S_CLEAR     = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [OW-1:0]      oc_q, oc_d;
  logic [NRW-1:0]     num_rows_q, num_rows_d;
  logic [NOW-1:0]     num_oc_q, num_oc_d;
  logic [Pix*RES-1:0] out_data_q, out_data_d;
  logic [RW-1:0]      out_row_q, out_row_d;
  logic [OW-1:0]      out_oc_q, out_oc_d;
  logic               row_last_s, oc_last_s;
  logic               wt_req_q, row_req_q, launch_q, clear_q, valid_q, busy_q, done_q;

  // Counters never pass the latched limits, so row+1 / oc+1 always fit the cfg width.
  assign row_last_s = (NRW'(row_q) + NRW'(1)) >= num_rows_q;
  assign oc_last_s  = (NOW'(oc_q) + NOW'(1)) >= num_oc_q;

  // Next-state, counter and result-capture logic.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    oc_d       = oc_q;
    num_rows_d = num_rows_q;
    num_oc_d   = num_oc_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    out_oc_d   = out_oc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = cfg_num_rows;
          num_oc_d   = cfg_num_oc;
          row_d      = '0;
          oc_d       = '0;
          if (cfg_num_rows == NRW'(0) || cfg_num_oc == NOW'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH_W;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_W: begin
        if (wt_ack) state_d = S_FETCH_ROW;
        else        state_d = S_FETCH_W;
      end
      S_FETCH_ROW: begin
        if (row_ack) state_d = S_LAUNCH;
        else         state_d = S_FETCH_ROW;
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (kernel_loop_done) begin
          out_data_d = acc_in;
          out_row_d  = row_q;
          out_oc_d   = oc_q;
          state_d    = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (out_ready) state_d = S_CLEAR;
        else           state_d = S_DRAIN;
      end
      S_CLEAR: begin
        if (!row_last_s) begin
          row_d   = row_q + RW'(1);
          state_d = S_FETCH_ROW;
        end else if (!oc_last_s) begin
          row_d   = '0;
          oc_d    = oc_q + OW'(1);
          state_d = S_FETCH_W;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      oc_q       <= '0;
      num_rows_q <= '0;
      num_oc_q   <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_oc_q   <= '0;
      wt_req_q   <= 1'b0;
      row_req_q  <= 1'b0;
      launch_q   <= 1'b0;
      clear_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      oc_q       <= oc_d;
      num_rows_q <= num_rows_d;
      num_oc_q   <= num_oc_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
      out_oc_q   <= out_oc_d;
      wt_req_q   <= (state_d == S_FETCH_W);
      row_req_q  <= (state_d == S_FETCH_ROW);
      launch_q   <= (state_d == S_LAUNCH);
      clear_q    <= (state_d == S_CLEAR);
      valid_q    <= (state_d == S_DRAIN);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign wt_req       = wt_req_q;
  assign wt_oc        = oc_q;
  assign row_req      = row_req_q;
  assign row_idx      = row_q;
  assign pixel_ready  = launch_q;
  assign weight_ready = launch_q;
  assign MAC_clear    = clear_q;
  assign out_valid    = valid_q;
  assign out_data     = out_data_q;
  assign out_row      = out_row_q;
  assign out_oc       = out_oc_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler: a reactive datapath/memory model
// answers requests while expected tile results are queued at job start.
module tb_conv_tile_scheduler;

  typedef struct packed {
    logic [23:0] data;
    logic [5:0]  row;
    logic [3:0]  oc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, start, wt_ack, row_ack, kernel_loop_done, out_ready;
  logic [6:0]  cfg_num_rows;
  logic [4:0]  cfg_num_oc;
  logic        wt_req, row_req, pixel_ready, weight_ready, MAC_clear, out_valid, busy, done;
  logic [3:0]  wt_oc, out_oc;
  logic [5:0]  row_idx, out_row;
  logic [23:0] acc_in, out_data;

  res_t       exp_q[$];
  logic [3:0] wt_oc_log[$];
  logic [5:0] row_idx_log[$];
  res_t       dummy;
  int checks = 0;
  int errors = 0;
  int n_wt, n_row, n_launch, n_clr, n_done, n_res, n_busy, done_cyc, launch_gap, last_launch;
  bit aborted;

  always #5 clk = ~clk;

  conv_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_rows(cfg_num_rows), .cfg_num_oc(cfg_num_oc),
    .wt_req(wt_req), .wt_oc(wt_oc), .wt_ack(wt_ack), .row_req(row_req), .row_idx(row_idx),
    .row_ack(row_ack), .pixel_ready(pixel_ready), .weight_ready(weight_ready),
    .MAC_clear(MAC_clear), .kernel_loop_done(kernel_loop_done), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_oc(out_oc), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job against a datapath model; acks come one cycle after a request rises.
  task automatic run_job(input int rows, input int ocs, input int lat, input int hold,
                         input logic [23:0] base, input logic [23:0] stepv,
                         input bit inject, input bit abort);
    int t, wt_wait, row_wait, since_launch, vcnt;
    bit fin, inj_done, clr_expected;
    logic prev_wt, prev_row;
    n_wt = 0; n_row = 0; n_launch = 0; n_clr = 0; n_done = 0; n_res = 0; n_busy = 0;
    done_cyc = -1; launch_gap = -1; last_launch = -1; aborted = 0;
    t = 0; wt_wait = 0; row_wait = 0; since_launch = -1; vcnt = 0;
    fin = 0; inj_done = 0; clr_expected = 0; prev_wt = 0; prev_row = 0;
    exp_q.delete(); wt_oc_log.delete(); row_idx_log.delete();
    for (int o = 0; o < ocs; o++)
      for (int r = 0; r < rows; r++)
        exp_q.push_back(res_t'{data: base + 24'(o*rows + r) * stepv, row: 6'(r), oc: 4'(o)});
    cfg_num_rows = 7'(rows);
    cfg_num_oc   = 5'(ocs);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wt_ack = 1'b0; row_ack = 1'b0; kernel_loop_done = 1'b0; out_ready = 1'b0; start = 1'b0;
      acc_in = 24'($urandom);
      n_busy += int'(busy);
      if (clr_expected) begin
        checks++;
        if (MAC_clear !== 1'b1) begin
          errors++; $display("FAIL clear_after_accept: MAC_clear=%b required 1", MAC_clear);
        end
        clr_expected = 0;
      end
      if (MAC_clear === 1'b1) n_clr++;
      checks++;
      if (pixel_ready !== weight_ready) begin
        errors++; $display("FAIL ready_pair: pixel_ready=%b weight_ready=%b required equal", pixel_ready, weight_ready);
      end
      if (pixel_ready === 1'b1) begin
        n_launch++;
        if (last_launch >= 0) launch_gap = cyc - last_launch;
        last_launch = cyc;
        since_launch = 0;
      end else if (since_launch >= 0) begin
        since_launch++;
      end
      if (wt_req === 1'b1 && !prev_wt) begin n_wt++; wt_oc_log.push_back(wt_oc); wt_wait = 0; end
      if (wt_req === 1'b1) begin wt_ack = (wt_wait == 1); wt_wait++; end
      if (row_req === 1'b1 && !prev_row) begin n_row++; row_idx_log.push_back(row_idx); row_wait = 0; end
      if (row_req === 1'b1) begin row_ack = (row_wait == 1); row_wait++; end
      if (since_launch == lat) begin
        kernel_loop_done = 1'b1;
        acc_in = base + 24'(t) * stepv;
        t++;
        since_launch = -1;
      end
      if (inject && !inj_done && since_launch == 2) begin
        start = 1'b1; cfg_num_rows = 7'd5; cfg_num_oc = 5'd9; row_ack = 1'b1; wt_ack = 1'b1;
        inj_done = 1;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL result_extra: got %h required none", {out_data, out_row, out_oc});
        end else if ({out_data, out_row, out_oc} !== exp_q[0]) begin
          errors++; $display("FAIL result: got data=%h row=%0d oc=%0d required %h", out_data, out_row, out_oc, exp_q[0]);
        end
        checks++;
        if ({MAC_clear, wt_req, row_req} !== 3'b000) begin
          errors++; $display("FAIL drain_quiet: clear/wt_req/row_req=%b required 000", {MAC_clear, wt_req, row_req});
        end
        if (abort && vcnt == 3) begin
          aborted = 1; fin = 1;
        end else if (vcnt >= hold) begin
          out_ready = 1'b1; n_res++;
          if (exp_q.size() > 0) dummy = exp_q.pop_front();
          clr_expected = 1; vcnt = 0;
        end else begin
          vcnt++;
        end
      end
      if (done === 1'b1) begin n_done++; done_cyc = cyc; fin = 1; end
      prev_wt = wt_req; prev_row = row_req;
      if (fin) break;
      step();
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL job_timeout: no done within budget, required done");
    end else if (!aborted) begin
      step();
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL post_done: done/busy=%b required 00", {done, busy});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wt_ack = 1'b0; row_ack = 1'b0; kernel_loop_done = 1'b0;
    out_ready = 1'b0; acc_in = 24'h0; cfg_num_rows = 7'd0; cfg_num_oc = 5'd0;
    step(); step();
    checks++;
    if ({wt_req, wt_oc, row_req, row_idx, pixel_ready, weight_ready, MAC_clear, out_valid,
         out_data, out_row, out_oc, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    rst = 1'b0;
    step();
    checks++;
    if ({busy, out_valid, done, wt_req, row_req} !== 5'b0) begin
      errors++; $display("FAIL reset_idle: busy/valid/done/wt_req/row_req=%b required 0", {busy, out_valid, done, wt_req, row_req});
    end
  endtask

  task automatic test_basic();
    run_job(2, 1, 9, 0, 24'h030201, 24'h000000, 0, 0);
    checks++; if (n_res !== 2)    begin errors++; $display("FAIL basic_results: got %0d required 2", n_res); end
    checks++; if (n_wt !== 1)     begin errors++; $display("FAIL basic_wt_req: got %0d required 1", n_wt); end
    checks++; if (n_row !== 2)    begin errors++; $display("FAIL basic_row_req: got %0d required 2", n_row); end
    checks++; if (n_launch !== 2) begin errors++; $display("FAIL basic_launch: got %0d required 2", n_launch); end
    checks++; if (n_clr !== 2)    begin errors++; $display("FAIL basic_clear: got %0d required 2", n_clr); end
    checks++; if (n_done !== 1)   begin errors++; $display("FAIL basic_done: got %0d required 1", n_done); end
    checks++; if (launch_gap !== 14) begin errors++; $display("FAIL basic_tile_period: got %0d required 14", launch_gap); end
    checks++;
    if (row_idx_log.size() != 2 || row_idx_log[0] !== 6'd0 || row_idx_log[1] !== 6'd1) begin
      errors++; $display("FAIL basic_row_idx: got %0d entries required rows 0,1", row_idx_log.size());
    end
  endtask

  task automatic test_multi_oc();
    run_job(1, 3, 4, 0, 24'h102030, 24'h010101, 0, 0);
    checks++; if (n_wt !== 3)  begin errors++; $display("FAIL multi_oc_wt_req: got %0d required 3", n_wt); end
    checks++; if (n_res !== 3) begin errors++; $display("FAIL multi_oc_results: got %0d required 3", n_res); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wt_oc_log.size() || wt_oc_log[i] !== 4'(i)) begin
        errors++; $display("FAIL multi_oc_wt_oc: index %0d log size %0d required oc %0d", i, wt_oc_log.size(), i);
      end
    end
  endtask

  task automatic test_backpressure();
    run_job(2, 2, 3, 20, 24'hA5A5A5, 24'h111111, 0, 0);
    checks++; if (n_res !== 4) begin errors++; $display("FAIL bp_results: got %0d required 4", n_res); end
    checks++; if (n_wt !== 2)  begin errors++; $display("FAIL bp_wt_req: got %0d required 2", n_wt); end
    checks++; if (n_clr !== 4) begin errors++; $display("FAIL bp_clear: got %0d required 4", n_clr); end
  endtask

  task automatic test_zero_cfg();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_job(0, 4, 3, 0, 24'h0, 24'h0, 0, 0);
      else        run_job(3, 0, 3, 0, 24'h0, 24'h0, 0, 0);
      checks++; if (done_cyc !== 0) begin errors++; $display("FAIL zero_done_latency: got %0d required 0", done_cyc); end
      checks++;
      if (n_wt + n_row + n_launch + n_clr + n_busy + n_res !== 0) begin
        errors++; $display("FAIL zero_activity: wt=%0d row=%0d launch=%0d clr=%0d busy=%0d res=%0d required 0",
                           n_wt, n_row, n_launch, n_clr, n_busy, n_res);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    run_job(2, 1, 6, 1, 24'h0F0E0D, 24'h020202, 1, 0);
    checks++; if (n_res !== 2)    begin errors++; $display("FAIL ignored_results: got %0d required 2", n_res); end
    checks++; if (n_launch !== 2) begin errors++; $display("FAIL ignored_launch: got %0d required 2", n_launch); end
    checks++; if (n_wt !== 1)     begin errors++; $display("FAIL ignored_wt_req: got %0d required 1", n_wt); end
  endtask

  task automatic test_abort();
    run_job(2, 1, 4, 10, 24'h445566, 24'h010203, 0, 1);
    checks++; if (!aborted) begin errors++; $display("FAIL abort_reached_drain: got 0 required 1"); end
    rst = 1'b1;
    step(); step();
    checks++;
    if ({wt_req, wt_oc, row_req, row_idx, pixel_ready, weight_ready, MAC_clear, out_valid,
         out_data, out_row, out_oc, busy, done} !== '0) begin
      errors++; $display("FAIL abort_reset_outputs: got nonzero outputs, required all 0");
    end
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles required 0", n_done); end
    run_job(1, 2, 2, 1, 24'h778899, 24'h101010, 0, 0);
    checks++; if (n_res !== 2)  begin errors++; $display("FAIL abort_rerun_results: got %0d required 2", n_res); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL abort_rerun_done: got %0d required 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_oc();
    test_backpressure();
    test_zero_cfg();
    test_ignored_inputs();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
